// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the mine board.
//   tile_state_t : per-tile state as stored in the tile-state RAM.
//   game_state_t : top-level game phase, read by draw and control blocks.
//   act_state_t  : phases of one read-modify-write tile action.
//   in_board()   : 1-based click coordinate range check.
package game_pkg;

  localparam int GAME_MAX_DIM = 32;
  localparam int GAME_ADDR_W  = 10;
  localparam int GAME_CNT_W   = 10;
  // Wide enough to hold button_num = 32 and the clear sweep coordinates.
  localparam int BN_W         = 6;

  localparam logic [BN_W-1:0] IDX_ZERO = 6'd0;
  localparam logic [BN_W-1:0] IDX_ONE  = 6'd1;

  typedef enum logic [1:0] {
    TILE_HIDDEN   = 2'd0,
    TILE_FLAGGED  = 2'd1,
    TILE_REVEALED = 2'd2
  } tile_state_t;

  typedef enum logic [2:0] {
    GS_IDLE    = 3'd0,
    GS_CLEAR   = 3'd1,
    GS_PLAYING = 3'd2,
    GS_WON     = 3'd3,
    GS_LOST    = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_RD   = 2'd1,
    ACT_EVAL = 2'd2,
    ACT_WR   = 2'd3
  } act_state_t;

  // True when (x,y) lies on a bn x bn board with 1-based indices.
  function automatic logic in_board(input logic [BN_W-1:0] x,
                                    input logic [BN_W-1:0] y,
                                    input logic [BN_W-1:0] bn);
    in_board = (x != IDX_ZERO) && (y != IDX_ZERO) && (x <= bn) && (y <= bn);
  endfunction

endpackage

// File: rtl/game_set_if.sv
// game_set_if: current game settings shared by the control blocks.
//   button_num : buttons per row/column of the active board (0..32).
interface game_set_if;
  import game_pkg::*;

  logic [BN_W-1:0] button_num;

  modport in (input button_num);
endinterface

// File: rtl/tile_action_ctrl_chk.sv
// tile_action_ctrl_chk: simulation checks on the board counters.
//   flag_inc/flag_dec/rev_inc : counter update strobes of the cycle
//   flag_cnt/revealed_cnt     : counter values before the update
module tile_action_ctrl_chk #(
  parameter int CNT_W = 10
) (
  input logic             clk,
  input logic             rst,
  input logic             flag_inc,
  input logic             flag_dec,
  input logic             rev_inc,
  input logic [CNT_W-1:0] flag_cnt,
  input logic [CNT_W-1:0] revealed_cnt
);

  localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_MAX  = {CNT_W{1'b1}};

  a_flag_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    flag_dec |-> (flag_cnt != C_ZERO));

  a_flag_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    flag_inc |-> (flag_cnt != C_MAX));

  a_rev_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    rev_inc |-> (revealed_cnt != C_MAX));

endmodule

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: combinational 1-based (x,y) to tile RAM address.
//   x, y : 1-based column/row (1..MAX_DIM)
//   addr : (y-1)*MAX_DIM + (x-1)
// Shared with the draw path so both sides agree on the RAM layout.
module tile_addr_gen #(
  parameter int MAX_DIM = 32,
  parameter int IDX_W   = 6,
  parameter int ADDR_W  = 10
) (
  input  logic [IDX_W-1:0]  x,
  input  logic [IDX_W-1:0]  y,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_DIM = ADDR_W'(MAX_DIM);

  // Row-major address, x fastest.
  always_comb begin
    addr = (ADDR_W'(y) - A_ONE) * A_DIM + (ADDR_W'(x) - A_ONE);
  end

endmodule

// File: rtl/tile_action_ctrl.sv
// tile_action_ctrl: sequences every access to the tile-state RAM.
//   clk, rst (async, active-low), start (new-game pulse)
//   bomb / flag            : reveal / flag-toggle levels, acted on at rising edge
//   button_index_x/y       : 1-based click coordinates, 0 = off board
//   in                     : game settings (button_num)
//   mine_num               : mines on the board
//   mem_addr/rd_en/wr_en/wdata, mem_rdata, mine_rdata : tile RAM port
//   busy, game_state, flag_cnt, revealed_cnt          : status
// Each accepted click becomes RD -> EVAL -> WR; start clears the board
// with one HIDDEN write per cycle before play begins.
module tile_action_ctrl
  import game_pkg::*;
#(
  parameter int MAX_DIM = GAME_MAX_DIM,
  parameter int ADDR_W  = GAME_ADDR_W,
  parameter int CNT_W   = GAME_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bomb,
  input  logic              flag,
  input  logic [4:0]        button_index_x,
  input  logic [4:0]        button_index_y,
  game_set_if.in            in,
  input  logic [CNT_W-1:0]  mine_num,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [1:0]        mem_wdata,
  input  logic [1:0]        mem_rdata,
  input  logic              mine_rdata,
  output logic              busy,
  output logic [2:0]        game_state,
  output logic [CNT_W-1:0]  flag_cnt,
  output logic [CNT_W-1:0]  revealed_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  game_state_t       game_r, game_nx;
  act_state_t        act_r, act_nx;
  logic              bomb_prev_r, flag_prev_r;
  logic              is_reveal_r, is_reveal_nx;
  logic [BN_W-1:0]   clr_x_r, clr_y_r, clr_x_nx, clr_y_nx;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_nx;
  logic              mem_rd_en_r, mem_rd_en_nx;
  logic              mem_wr_en_r, mem_wr_en_nx;
  logic [1:0]        mem_wdata_r, mem_wdata_nx;
  logic              busy_r, busy_nx;
  logic [CNT_W-1:0]  flag_cnt_r, flag_cnt_nx;
  logic [CNT_W-1:0]  rev_cnt_r, rev_cnt_nx;

  logic              bomb_rise_s, flag_rise_s, click_s, clr_last_s;
  logic [BN_W-1:0]   bn_s, bx_s, by_s, gen_x_s, gen_y_s;
  logic [BN_W-1:0]   clr_step_x_s, clr_step_y_s;
  logic [ADDR_W-1:0] gen_addr_s;
  logic [CNT_W-1:0]  win_target_s, rev_next_s;
  logic              flag_inc_s, flag_dec_s, rev_inc_s;

  tile_addr_gen #(
    .MAX_DIM (MAX_DIM),
    .IDX_W   (BN_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .x    (gen_x_s),
    .y    (gen_y_s),
    .addr (gen_addr_s)
  );

  tile_action_ctrl_chk #(
    .CNT_W (CNT_W)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .flag_inc     (flag_inc_s),
    .flag_dec     (flag_dec_s),
    .rev_inc      (rev_inc_s),
    .flag_cnt     (flag_cnt_r),
    .revealed_cnt (rev_cnt_r)
  );

  // Click decode, clear-sweep stepping, win threshold and address source.
  always_comb begin
    bn_s        = in.button_num;
    bx_s        = BN_W'(button_index_x);
    by_s        = BN_W'(button_index_y);
    bomb_rise_s = bomb & ~bomb_prev_r;
    flag_rise_s = flag & ~flag_prev_r;
    click_s     = (game_r == GS_PLAYING) && (act_r == ACT_IDLE) &&
                  in_board(bx_s, by_s, bn_s) && (bomb_rise_s || flag_rise_s);
    // >= rather than == so a mid-sweep shrink of button_num still terminates.
    clr_last_s  = (clr_x_r >= bn_s) && (clr_y_r >= bn_s);
    if (clr_x_r >= bn_s) begin
      clr_step_x_s = IDX_ONE;
      clr_step_y_s = clr_y_r + IDX_ONE;
    end else begin
      clr_step_x_s = clr_x_r + IDX_ONE;
      clr_step_y_s = clr_y_r;
    end
    // Board area is taken modulo 2**CNT_W on purpose.
    win_target_s = CNT_W'(bn_s) * CNT_W'(bn_s) - mine_num;
    rev_next_s   = rev_cnt_r + CNT_ONE;
    if (start) begin
      gen_x_s = IDX_ONE;
      gen_y_s = IDX_ONE;
    end else if (game_r == GS_CLEAR) begin
      gen_x_s = clr_step_x_s;
      gen_y_s = clr_step_y_s;
    end else begin
      gen_x_s = bx_s;
      gen_y_s = by_s;
    end
  end

  // Game and action next-state plus registered-output next values.
  always_comb begin
    game_nx      = game_r;
    act_nx       = act_r;
    is_reveal_nx = is_reveal_r;
    clr_x_nx     = clr_x_r;
    clr_y_nx     = clr_y_r;
    mem_addr_nx  = mem_addr_r;
    mem_rd_en_nx = 1'b0;
    mem_wr_en_nx = 1'b0;
    mem_wdata_nx = mem_wdata_r;
    busy_nx      = busy_r;
    flag_cnt_nx  = flag_cnt_r;
    rev_cnt_nx   = rev_cnt_r;
    flag_inc_s   = 1'b0;
    flag_dec_s   = 1'b0;
    rev_inc_s    = 1'b0;
    if (start) begin
      // start overrides everything, including a half-done action.
      act_nx      = ACT_IDLE;
      flag_cnt_nx = CNT_ZERO;
      rev_cnt_nx  = CNT_ZERO;
      clr_x_nx    = IDX_ONE;
      clr_y_nx    = IDX_ONE;
      if (bn_s == IDX_ZERO) begin
        game_nx = GS_IDLE;
        busy_nx = 1'b0;
      end else begin
        game_nx      = GS_CLEAR;
        mem_addr_nx  = gen_addr_s;
        mem_wr_en_nx = 1'b1;
        mem_wdata_nx = TILE_HIDDEN;
        busy_nx      = 1'b1;
      end
    end else begin
      case (game_r)
        GS_CLEAR: begin
          act_nx = ACT_IDLE;
          if (clr_last_s) begin
            game_nx = GS_PLAYING;
            busy_nx = 1'b0;
          end else begin
            clr_x_nx     = clr_step_x_s;
            clr_y_nx     = clr_step_y_s;
            mem_addr_nx  = gen_addr_s;
            mem_wr_en_nx = 1'b1;
            mem_wdata_nx = TILE_HIDDEN;
            busy_nx      = 1'b1;
          end
        end
        GS_PLAYING: begin
          case (act_r)
            ACT_IDLE: begin
              if (click_s) begin
                act_nx       = ACT_RD;
                is_reveal_nx = bomb_rise_s;  // bomb wins a tie with flag
                mem_addr_nx  = gen_addr_s;
                mem_rd_en_nx = 1'b1;
                busy_nx      = 1'b1;
              end else begin
                busy_nx = 1'b0;
              end
            end
            ACT_RD: begin
              act_nx = ACT_EVAL;
            end
            ACT_EVAL: begin
              // Read data is valid now; the decision lands in the WR cycle.
              act_nx = ACT_WR;
              if (is_reveal_r) begin
                case (tile_state_t'(mem_rdata))
                  TILE_HIDDEN: begin
                    mem_wr_en_nx = 1'b1;
                    mem_wdata_nx = TILE_REVEALED;
                    if (mine_rdata) begin
                      game_nx = GS_LOST;
                    end else begin
                      rev_cnt_nx = rev_next_s;
                      rev_inc_s  = 1'b1;
                      if (rev_next_s == win_target_s) begin
                        game_nx = GS_WON;
                      end else begin
                        game_nx = GS_PLAYING;
                      end
                    end
                  end
                  default: begin
                    mem_wr_en_nx = 1'b0;  // flagged/revealed tiles are protected
                  end
                endcase
              end else begin
                case (tile_state_t'(mem_rdata))
                  TILE_HIDDEN: begin
                    if (flag_cnt_r < mine_num) begin
                      mem_wr_en_nx = 1'b1;
                      mem_wdata_nx = TILE_FLAGGED;
                      flag_cnt_nx  = flag_cnt_r + CNT_ONE;
                      flag_inc_s   = 1'b1;
                    end else begin
                      mem_wr_en_nx = 1'b0;
                    end
                  end
                  TILE_FLAGGED: begin
                    mem_wr_en_nx = 1'b1;
                    mem_wdata_nx = TILE_HIDDEN;
                    flag_cnt_nx  = flag_cnt_r - CNT_ONE;
                    flag_dec_s   = 1'b1;
                  end
                  default: begin
                    mem_wr_en_nx = 1'b0;
                  end
                endcase
              end
            end
            ACT_WR: begin
              act_nx  = ACT_IDLE;
              busy_nx = 1'b0;
            end
            default: begin
              act_nx  = ACT_IDLE;
              busy_nx = 1'b0;
            end
          endcase
        end
        default: begin
          // IDLE/WON/LOST: finishing action (if any) retires here.
          act_nx  = ACT_IDLE;
          busy_nx = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; edge-detect history updates every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game_r      <= GS_IDLE;
      act_r       <= ACT_IDLE;
      bomb_prev_r <= 1'b0;
      flag_prev_r <= 1'b0;
      is_reveal_r <= 1'b0;
      clr_x_r     <= IDX_ZERO;
      clr_y_r     <= IDX_ZERO;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_rd_en_r <= 1'b0;
      mem_wr_en_r <= 1'b0;
      mem_wdata_r <= 2'd0;
      busy_r      <= 1'b0;
      flag_cnt_r  <= CNT_ZERO;
      rev_cnt_r   <= CNT_ZERO;
    end else begin
      game_r      <= game_nx;
      act_r       <= act_nx;
      bomb_prev_r <= bomb;
      flag_prev_r <= flag;
      is_reveal_r <= is_reveal_nx;
      clr_x_r     <= clr_x_nx;
      clr_y_r     <= clr_y_nx;
      mem_addr_r  <= mem_addr_nx;
      mem_rd_en_r <= mem_rd_en_nx;
      mem_wr_en_r <= mem_wr_en_nx;
      mem_wdata_r <= mem_wdata_nx;
      busy_r      <= busy_nx;
      flag_cnt_r  <= flag_cnt_nx;
      rev_cnt_r   <= rev_cnt_nx;
    end
  end

  assign mem_addr     = mem_addr_r;
  assign mem_rd_en    = mem_rd_en_r;
  assign mem_wr_en    = mem_wr_en_r;
  assign mem_wdata    = mem_wdata_r;
  assign busy         = busy_r;
  assign game_state   = game_r;
  assign flag_cnt     = flag_cnt_r;
  assign revealed_cnt = rev_cnt_r;

endmodule

// File: tb/tb_tile_action_ctrl.sv
// tb_tile_action_ctrl: scoreboard bench for tile_action_ctrl.
// Expected RAM accesses (kind, address, data, cycle) are queued when a
// click or start is driven and popped when the DUT strobes the RAM.
module tb_tile_action_ctrl;

  typedef struct {
    bit wr;
    int addr;
    int data;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       bomb = 1'b0;
  logic       flag = 1'b0;
  logic [4:0] bx = 5'd0;
  logic [4:0] by = 5'd0;
  logic [9:0] mine_num = 10'd0;
  logic [9:0] mem_addr;
  logic       mem_rd_en, mem_wr_en;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata = 2'd0;
  logic       mine_rdata = 1'b0;
  logic       busy;
  logic [2:0] game_state;
  logic [9:0] flag_cnt, revealed_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  ev_t sb[$];

  logic [1:0] tile_mem [0:1023];
  bit         mine_map [0:1023];
  bit [1:0]   m_tile   [0:1023];
  int m_gs = 0;
  int m_flag = 0;
  int m_rev = 0;

  game_set_if gs_if();

  tile_action_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .bomb           (bomb),
    .flag           (flag),
    .button_index_x (bx),
    .button_index_y (by),
    .in             (gs_if),
    .mine_num       (mine_num),
    .mem_addr       (mem_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mine_rdata     (mine_rdata),
    .busy           (busy),
    .game_state     (game_state),
    .flag_cnt       (flag_cnt),
    .revealed_cnt   (revealed_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tile RAM and mine map with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata  <= tile_mem[mem_addr];
      mine_rdata <= mine_map[mem_addr];
    end
    if (mem_wr_en) tile_mem[mem_addr] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  ev_t mon_e;
  // Pop one expected access for every observed RAM strobe.
  always @(negedge clk) begin
    if (rst && (mem_rd_en || mem_wr_en)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_access", {22'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check_eq("ev_wr", {31'd0, mem_wr_en}, {31'd0, mon_e.wr});
        check_eq("ev_rd", {31'd0, mem_rd_en}, {31'd0, !mon_e.wr});
        check_eq("ev_addr", {22'd0, mem_addr}, mon_e.addr);
        check_eq("ev_cycle", cyc, mon_e.cyc);
        if (mon_e.wr) check_eq("ev_wdata", {30'd0, mem_wdata}, mon_e.data);
      end
    end
  end

  function automatic ev_t mk(input bit wr, input int addr, input int data, input int c);
    ev_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.cyc = c;
    return e;
  endfunction

  task automatic do_start(input int bn);
    int s, k, a;
    s = cyc;
    gs_if.button_num = 6'(bn);
    start = 1'b1;
    m_flag = 0;
    m_rev = 0;
    if (bn > 0) begin
      k = 0;
      for (int y = 1; y <= bn; y++) begin
        for (int x = 1; x <= bn; x++) begin
          a = (y - 1) * 32 + (x - 1);
          sb.push_back(mk(1'b1, a, 0, s + 1 + k));
          m_tile[a] = 2'd0;
          k++;
        end
      end
      m_gs = 1;
    end else begin
      m_gs = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("start_busy", {31'd0, busy}, (bn > 0) ? 32'd1 : 32'd0);
    check_eq("start_state", {29'd0, game_state}, m_gs);
    if (bn > 0) begin
      repeat (bn * bn) @(negedge clk);
      m_gs = 2;
      check_eq("clear_done_state", {29'd0, game_state}, m_gs);
      check_eq("clear_done_busy", {31'd0, busy}, 32'd0);
      check_eq("clear_flag_cnt", {22'd0, flag_cnt}, 32'd0);
      check_eq("clear_rev_cnt", {22'd0, revealed_cnt}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  // mode 0: plain click; 1: extra flag edge while busy; 2: start at N+2.
  task automatic click(input int x, input int y, input bit b, input bit f, input int mode);
    int n, a, bn, target;
    bit acc;
    bn = int'(gs_if.button_num);
    n = cyc;
    bx = 5'(x);
    by = 5'(y);
    bomb = b;
    flag = f;
    acc = (m_gs == 2) && (x >= 1) && (y >= 1) && (x <= bn) && (y <= bn) && (b || f);
    a = (y - 1) * 32 + (x - 1);
    target = (bn * bn - int'(mine_num)) & 1023;
    if (acc) begin
      sb.push_back(mk(1'b0, a, 0, n + 1));
      if (mode != 2) begin
        if (b) begin
          if (m_tile[a] == 2'd0) begin
            sb.push_back(mk(1'b1, a, 2, n + 3));
            m_tile[a] = 2'd2;
            if (mine_map[a]) m_gs = 4;
            else begin
              m_rev++;
              if (m_rev == target) m_gs = 3;
            end
          end
        end else begin
          if (m_tile[a] == 2'd0 && m_flag < int'(mine_num)) begin
            sb.push_back(mk(1'b1, a, 1, n + 3));
            m_tile[a] = 2'd1;
            m_flag++;
          end else if (m_tile[a] == 2'd1) begin
            sb.push_back(mk(1'b1, a, 0, n + 3));
            m_tile[a] = 2'd0;
            m_flag--;
          end
        end
      end
    end
    @(posedge clk); #1;
    bomb = 1'b0;
    flag = 1'b0;
    @(negedge clk);
    check_eq("busy_n1", {31'd0, busy}, {31'd0, acc});
    @(posedge clk); #1;
    if (mode == 2) begin
      do_start(bn);
      return;
    end
    if (mode == 1) begin
      bx = 5'd4;
      by = 5'd1;
      flag = 1'b1;
    end
    @(posedge clk); #1;
    flag = 1'b0;
    @(negedge clk);
    check_eq("state_n3", {29'd0, game_state}, m_gs);
    @(negedge clk);
    check_eq("busy_n4", {31'd0, busy}, 32'd0);
    check_eq("flag_cnt", {22'd0, flag_cnt}, m_flag);
    check_eq("revealed_cnt", {22'd0, revealed_cnt}, m_rev);
    check_eq("state_n4", {29'd0, game_state}, m_gs);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 1024; i++) begin
      tile_mem[i] = 2'd1;
      mine_map[i] = 1'b0;
      m_tile[i] = 2'd1;
    end
    gs_if.button_num = 6'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_state", {29'd0, game_state}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check_eq("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check_eq("rst_flag_cnt", {22'd0, flag_cnt}, 32'd0);
    check_eq("rst_rev_cnt", {22'd0, revealed_cnt}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 4x4 board, three mines.
    mine_num = 10'd3;
    mine_map[34] = 1'b1;
    mine_map[99] = 1'b1;
    mine_map[96] = 1'b1;
    do_start(4);
    click(2, 1, 1'b0, 1'b1, 0);   // flag on
    click(2, 1, 1'b0, 1'b1, 0);   // flag off
    click(1, 1, 1'b0, 1'b1, 0);   // flag (1,1)
    click(1, 1, 1'b1, 1'b0, 0);   // protected reveal
    click(5, 1, 1'b1, 1'b0, 0);   // off board
    click(0, 2, 1'b1, 1'b0, 0);   // off board
    click(2, 2, 1'b1, 1'b1, 0);   // tie: reveal wins
    click(1, 2, 1'b1, 1'b0, 1);   // flag edge while busy dropped
    click(3, 3, 1'b1, 1'b0, 2);   // start pre-empts, board cleared
    click(4, 1, 1'b0, 1'b1, 0);   // flag, fresh board
    click(3, 2, 1'b1, 1'b0, 0);   // mine -> LOST
    click(1, 1, 1'b1, 1'b0, 0);   // ignored after loss

    // 2x2 board, one mine: three safe reveals win.
    for (int i = 0; i < 1024; i++) mine_map[i] = 1'b0;
    mine_map[33] = 1'b1;
    mine_num = 10'd1;
    do_start(2);
    click(1, 1, 1'b1, 1'b0, 0);
    click(2, 1, 1'b1, 1'b0, 0);
    click(1, 2, 1'b1, 1'b0, 0);
    check_eq("won", {29'd0, game_state}, 32'd3);

    // Flag limit reached: second flag must not write.
    do_start(2);
    click(1, 1, 1'b0, 1'b1, 0);
    click(2, 1, 1'b0, 1'b1, 0);
    click(2, 2, 1'b1, 1'b0, 0);

    // Empty board: start stays in IDLE.
    do_start(0);
    click(1, 1, 1'b1, 1'b0, 0);

    // Reset during clear: strobes drop without waiting for a clock.
    s = cyc;
    gs_if.button_num = 6'd4;
    start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(mk(1'b1, k, 0, s + 1 + k));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    #2;
    check_eq("pre_rst_wr_en", {31'd0, mem_wr_en}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("async_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("async_rst_state", {29'd0, game_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_after_rst", {29'd0, game_state}, 32'd0);
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
